// File: rtl/ucaspian_synapse_if.sv
// Range-in / event-out handshake bundle for the synapse stage.
// Ports: syn_start/syn_end/syn_vld/syn_rdy carry one inclusive index range from the axon stage;
//        dendrite_addr/dendrite_weight/dendrite_vld/dendrite_rdy carry (neuron, weight) events out.
interface ucaspian_synapse_if #(
    parameter int SYN_AW    = 12,
    parameter int NEURON_AW = 8,
    parameter int WEIGHT_W  = 8
);
    logic [SYN_AW-1:0]           syn_start;
    logic [SYN_AW-1:0]           syn_end;
    logic                        syn_vld;
    logic                        syn_rdy;
    logic [NEURON_AW-1:0]        dendrite_addr;
    logic signed [WEIGHT_W-1:0]  dendrite_weight;
    logic                        dendrite_vld;
    logic                        dendrite_rdy;

    // master: axon-side range producer plus the dendrite-side event consumer
    modport master (
        output syn_start, syn_end, syn_vld, dendrite_rdy,
        input  syn_rdy, dendrite_addr, dendrite_weight, dendrite_vld
    );

    // slave: the synapse stage itself
    modport slave (
        input  syn_start, syn_end, syn_vld, dendrite_rdy,
        output syn_rdy, dendrite_addr, dendrite_weight, dendrite_vld
    );
endinterface

// File: rtl/ucaspian_synapse.sv
// Synapse stage: walks an inclusive synapse-index range, reads each RAM entry, emits (neuron, weight) events.
// Latency: range accepted at edge E0, first event valid after E2; then one event per cycle.
// Backpressure: dendrite_rdy low holds the output register; one skid entry absorbs the in-flight read.
// Ports: clk/reset; clear_config/clear_done (RAM sweep clear); config_* (shadow-register RAM writes);
//        syn_if (range in, events out); idle (nothing pending, in flight or buffered).
module ucaspian_synapse #(
    parameter int SYN_AW    = 12,
    parameter int NEURON_AW = 8,
    parameter int WEIGHT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_config,
    output logic              clear_done,
    input  logic [SYN_AW-1:0] config_addr,
    input  logic [11:0]       config_value,
    input  logic [2:0]        config_byte,
    input  logic              config_enable,
    ucaspian_synapse_if.slave syn_if,
    output logic              idle
);
    localparam int DW = WEIGHT_W + NEURON_AW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR} state_t;

    state_t              state_q, state_d;
    logic [SYN_AW:0]     cur_q, cur_d;          // one extra bit so end=max terminates without wrap
    logic [SYN_AW-1:0]   last_q, last_d;
    logic                rd_pend_q, rd_pend_d;
    logic [DW-1:0]       rd_dat_q;
    logic                out_vld_q, out_vld_d;
    logic [DW-1:0]       out_dat_q, out_dat_d;
    logic                skid_vld_q, skid_vld_d;
    logic [DW-1:0]       skid_dat_q, skid_dat_d;
    logic [DW-1:0]       shadow_q, shadow_d;
    logic [SYN_AW:0]     clr_addr_q, clr_addr_d;
    logic                clear_done_q, clear_done_d;
    logic                idle_q, idle_d;

    logic [DW-1:0]       syn_mem [2**SYN_AW];
    logic                mem_we;
    logic [SYN_AW-1:0]   mem_waddr;
    logic [DW-1:0]       mem_wdat;

    logic walk_done, stall, out_free, rd_issue;

    assign walk_done = cur_q > {1'b0, last_q};
    assign stall     = out_vld_q && !syn_if.dendrite_rdy;
    assign out_free  = !out_vld_q || syn_if.dendrite_rdy;
    // Never issue with the skid occupied or the output stalled: the one read in flight
    // then always has somewhere to land.
    assign rd_issue  = (state_q == S_RUN) && !walk_done && !skid_vld_q && !stall;

    assign syn_if.syn_rdy         = (state_q == S_IDLE) && !clear_config;
    assign syn_if.dendrite_vld    = out_vld_q;
    assign syn_if.dendrite_addr   = out_dat_q[NEURON_AW-1:0];
    assign syn_if.dendrite_weight = out_dat_q[DW-1:NEURON_AW];
    assign clear_done             = clear_done_q;
    assign idle                   = idle_q;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        rd_pend_d  = rd_issue;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        shadow_d   = shadow_q;
        clr_addr_d = '0;
        mem_we     = 1'b0;
        mem_waddr  = config_addr;
        mem_wdat   = shadow_q;

        case (state_q)
            S_IDLE: begin
                if (syn_if.syn_vld && syn_if.syn_rdy) begin
                    state_d = S_RUN;
                    cur_d   = {1'b0, syn_if.syn_start};
                    last_d  = syn_if.syn_end;
                end
            end
            S_RUN: begin
                if (rd_issue) cur_d = cur_q + (SYN_AW+1)'(1);
                // The output register may still hold an event; only the walk must be finished.
                if (walk_done && !rd_pend_q && !skid_vld_q) state_d = S_IDLE;
            end
            S_CLEAR: begin
                clr_addr_d = clr_addr_q;
                state_d    = S_IDLE;
                if (clear_config && !clr_addr_q[SYN_AW]) begin
                    mem_we     = 1'b1;
                    mem_waddr  = clr_addr_q[SYN_AW-1:0];
                    mem_wdat   = '0;
                    clr_addr_d = clr_addr_q + (SYN_AW+1)'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output pipeline: skid has priority over fresh read data to keep index order.
        if (out_free) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = rd_pend_q;
                if (rd_pend_q) skid_dat_d = rd_dat_q;
            end else if (rd_pend_q) begin
                out_vld_d = 1'b1;
                out_dat_d = rd_dat_q;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (rd_pend_q) begin
            skid_vld_d = 1'b1;
            skid_dat_d = rd_dat_q;
        end

        if (!clear_config && config_enable) begin
            case (config_byte)
                3'd1: shadow_d = '0;
                3'd2: shadow_d[DW-1:NEURON_AW] = config_value[WEIGHT_W-1:0];
                3'd3: shadow_d[NEURON_AW-1:0]  = config_value[NEURON_AW-1:0];
                3'd4: mem_we = 1'b1;
                default: ;
            endcase
        end

        // Clear aborts everything in flight, from any state.
        if (clear_config) begin
            state_d    = S_CLEAR;
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            rd_pend_d  = 1'b0;
        end

        clear_done_d = clear_config && (state_q == S_CLEAR) && clr_addr_q[SYN_AW];
        idle_d       = (state_q == S_IDLE) && !out_vld_q && !skid_vld_q && !syn_if.syn_vld;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            last_q       <= '0;
            rd_pend_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_dat_q    <= '0;
            skid_vld_q   <= 1'b0;
            skid_dat_q   <= '0;
            shadow_q     <= '0;
            clr_addr_q   <= '0;
            clear_done_q <= 1'b0;
            idle_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            rd_pend_q    <= rd_pend_d;
            out_vld_q    <= out_vld_d;
            out_dat_q    <= out_dat_d;
            skid_vld_q   <= skid_vld_d;
            skid_dat_q   <= skid_dat_d;
            shadow_q     <= shadow_d;
            clr_addr_q   <= clr_addr_d;
            clear_done_q <= clear_done_d;
            idle_q       <= idle_d;
        end
    end

    // Synapse RAM: contents are not reset; one write port, one registered read port.
    always_ff @(posedge clk) begin
        if (mem_we)   syn_mem[mem_waddr] <= mem_wdat;
        if (rd_issue) rd_dat_q <= syn_mem[cur_q[SYN_AW-1:0]];
    end
endmodule

// File: tb/tb_ucaspian_synapse.sv
// Self-checking bench for ucaspian_synapse: directed scenarios plus randomized ranges and backpressure,
// checked against a word-array model of the synapse RAM and an expected-event queue.
// All stimulus changes and all sampling happen on the falling clock edge.
module tb_ucaspian_synapse;
    logic        clk = 1'b0;
    logic        reset;
    logic        clear_config;
    logic        clear_done;
    logic [11:0] config_addr;
    logic [11:0] config_value;
    logic [2:0]  config_byte;
    logic        config_enable;
    logic        idle;

    ucaspian_synapse_if ifc ();

    ucaspian_synapse dut (
        .clk           (clk),
        .reset         (reset),
        .clear_config  (clear_config),
        .clear_done    (clear_done),
        .config_addr   (config_addr),
        .config_value  (config_value),
        .config_byte   (config_byte),
        .config_enable (config_enable),
        .syn_if        (ifc),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    logic [15:0] ref_mem [4096];   // {weight, neuron} as written by the bench
    logic [15:0] exp_q [$];        // events still owed by the DUT, in index order
    int          total = 0;
    int          bad   = 0;
    int          n_got = 0;
    bit          mon_en = 1'b1;
    int          rdy_mode = 1;     // 0: hold low, 1: hold high, 2: random
    bit          prev_hold = 1'b0;
    logic [15:0] prev_dat = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mon_step();
        logic [15:0] obs;
        obs = {ifc.dendrite_weight, ifc.dendrite_addr};
        if (mon_en) begin
            if (prev_hold) begin
                chk("hold_vld", 32'(ifc.dendrite_vld), 32'd1);
                chk("hold_dat", 32'(obs), 32'(prev_dat));
            end
            if (ifc.dendrite_vld && ifc.dendrite_rdy) begin
                chk("event_owed", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("event_dat", 32'(obs), 32'(exp_q.pop_front()));
                n_got++;
            end
            prev_hold = ifc.dendrite_vld && !ifc.dendrite_rdy;
        end else begin
            prev_hold = 1'b0;
        end
        prev_dat = obs;
    endtask

    // Advance to the next falling edge, set the consumer ready for the coming rising edge, then observe.
    task automatic tick();
        @(negedge clk);
        case (rdy_mode)
            0:       ifc.dendrite_rdy = 1'b0;
            1:       ifc.dendrite_rdy = 1'b1;
            default: ifc.dendrite_rdy = ($urandom_range(0, 3) != 0);
        endcase
        mon_step();
    endtask

    task automatic cfg_write(input int addr, input logic [7:0] w, input logic [7:0] n);
        config_addr   = 12'(addr);
        config_enable = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            config_byte  = 3'(b);
            config_value = (b == 2) ? {4'h0, w} : (b == 3) ? {4'h0, n} : 12'h0;
            tick();
        end
        config_enable = 1'b0;
        config_byte   = 3'd0;
        ref_mem[addr] = {w, n};
    endtask

    // Returns at the falling edge just after the accepting rising edge.
    task automatic send_range(input int s, input int e);
        bit ok;
        ok = 1'b0;
        ifc.syn_start = 12'(s);
        ifc.syn_end   = 12'(e);
        ifc.syn_vld   = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (ifc.syn_rdy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("range_accept", 32'(ok), 32'd1);
        if (ok) for (int i = s; i <= e; i++) exp_q.push_back(ref_mem[i]);
        tick();
        ifc.syn_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && ifc.syn_rdy && !ifc.dendrite_vld) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_vld(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ifc.dendrite_vld) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    // clear_config is raised at the current falling edge; the sweep completes 4097 edges after entry.
    task automatic run_clear(input string tag);
        int first;
        first = 0;
        clear_config = 1'b1;
        for (int k = 1; k <= 4100; k++) begin
            tick();
            if (k == 1) chk({tag, "_vld_drop"}, 32'(ifc.dendrite_vld), 32'd0);
            if (clear_done && first == 0) first = k;
        end
        chk({tag, "_done_at"}, 32'(first), 32'd4098);
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        exp_q.delete();
        clear_config = 1'b0;
        tick();
        chk({tag, "_done_low"}, 32'(clear_done), 32'd0);
        chk({tag, "_syn_rdy"}, 32'(ifc.syn_rdy), 32'd1);
    endtask

    initial begin
        int n0, s, e, len;
        reset = 1'b1;
        clear_config = 1'b0;
        config_addr = '0;
        config_value = '0;
        config_byte = '0;
        config_enable = 1'b0;
        ifc.syn_start = '0;
        ifc.syn_end = '0;
        ifc.syn_vld = 1'b0;
        ifc.dendrite_rdy = 1'b1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;

        tick();
        tick();
        chk("rst_vld", 32'(ifc.dendrite_vld), 32'd0);
        chk("rst_addr", 32'(ifc.dendrite_addr), 32'd0);
        chk("rst_weight", 32'(ifc.dendrite_weight), 32'd0);
        chk("rst_clear_done", 32'(clear_done), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);
        chk("rst_syn_rdy", 32'(ifc.syn_rdy), 32'd1);
        reset = 1'b0;
        tick();

        // Establish known RAM contents.
        run_clear("clr0");

        // Three entries, full throughput, latency and handshake timing.
        rdy_mode = 1;
        cfg_write(10, 8'h05, 8'h03);
        cfg_write(11, 8'hFE, 8'h07);
        cfg_write(12, 8'h00, 8'h09);
        n0 = n_got;
        send_range(10, 12);
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) tick();
            chk($sformatf("t1_vld%0d", i), 32'(ifc.dendrite_vld), 32'((i >= 2) && (i <= 4)));
            if (i <= 4) chk($sformatf("t1_busy%0d", i), 32'(ifc.syn_rdy), 32'd0);
            if (i == 5) chk("t1_syn_rdy", 32'(ifc.syn_rdy), 32'd1);
            if (i == 6) chk("t1_idle", 32'(idle), 32'd1);
        end
        chk("t1_count", 32'(n_got - n0), 32'd3);

        // Same range with the consumer stalled once the first event appears.
        rdy_mode = 0;
        n0 = n_got;
        send_range(10, 12);
        wait_vld("t2_first");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_busy", 32'(ifc.syn_rdy), 32'd0);
        end
        rdy_mode = 1;
        wait_done("t2_done");
        chk("t2_count", 32'(n_got - n0), 32'd3);

        // Top of the index space.
        cfg_write(0, 8'h7F, 8'hAA);
        cfg_write(4094, 8'h81, 8'h11);
        cfg_write(4095, 8'h33, 8'hFF);
        n0 = n_got;
        send_range(4094, 4095);
        wait_done("t3_done");
        chk("t3_count", 32'(n_got - n0), 32'd2);

        // Empty range.
        n0 = n_got;
        send_range(20, 19);
        chk("t4_vld0", 32'(ifc.dendrite_vld), 32'd0);
        tick();
        chk("t4_syn_rdy", 32'(ifc.syn_rdy), 32'd1);
        tick();
        chk("t4_count", 32'(n_got - n0), 32'd0);

        // Randomized ranges, configs and backpressure.
        rdy_mode = 2;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1)
                cfg_write($urandom_range(0, 1) ? $urandom_range(0, 70) : $urandom_range(4085, 4095),
                          8'($urandom), 8'($urandom));
            s   = $urandom_range(0, 2) != 0 ? $urandom_range(1, 64) : $urandom_range(4086, 4095);
            len = $urandom_range(0, 7);
            e   = s + len - 1;
            if (e > 4095) e = 4095;
            n0 = n_got;
            send_range(s, e);
            wait_done("rnd_done");
            chk("rnd_count", 32'(n_got - n0), 32'(e - s + 1));
        end

        // Clear in the middle of a stalled range, then read back the cleared entries.
        rdy_mode = 0;
        send_range(10, 12);
        wait_vld("t5_first");
        mon_en = 1'b0;
        run_clear("t5");
        mon_en = 1'b1;
        rdy_mode = 1;
        n0 = n_got;
        send_range(10, 12);
        wait_done("t5_readback");
        chk("t5_count", 32'(n_got - n0), 32'd3);

        // Asynchronous reset between edges during a stalled range.
        rdy_mode = 0;
        cfg_write(30, 8'h12, 8'h34);
        send_range(30, 32);
        wait_vld("t6_first");
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6_vld", 32'(ifc.dendrite_vld), 32'd0);
        chk("t6_clear_done", 32'(clear_done), 32'd0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_syn_rdy", 32'(ifc.syn_rdy), 32'd1);
        tick();
        chk("t6_idle", 32'(idle), 32'd1);
        mon_en = 1'b1;
        rdy_mode = 1;
        n0 = n_got;
        send_range(30, 30);
        wait_done("t6_after");
        chk("t6_count", 32'(n_got - n0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ucaspian_synapse.md
Name: ucaspian_synapse

Overview:
- Synapse stage, directly downstream of the axon stage.
- Accepts one inclusive synapse-index range per handshake (syn_start..syn_end), walks it one synapse per cycle, and reads each entry from a 4096-entry synapse RAM.
- Emits a (target neuron, signed weight) event per synapse to the dendrite/neuron accumulation stage.
- Also owns synapse-RAM configuration and clearing.

Parameters:
- SYN_AW, 12, synapse index width (RAM depth 2^SYN_AW = 4096)
- NEURON_AW, 8, target neuron address width
- WEIGHT_W, 8, signed weight width (RAM word = WEIGHT_W+NEURON_AW = 16)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clear_config  in  1  sweep-clear synapse RAM while held
- clear_done  out  1  clear sweep complete
- config_addr  in  12  synapse index for config write
- config_value  in  12  config payload
- config_byte  in  3  config sub-step
- config_enable  in  1  config strobe
- syn_start  in  12  first synapse index (from axon)
- syn_end  in  12  last synapse index, inclusive
- syn_vld  in  1  range valid
- syn_rdy  out  1  range accepted when syn_vld&&syn_rdy
- dendrite_addr  out  8  target neuron
- dendrite_weight  out  8  signed weight
- dendrite_vld  out  1  event valid
- dendrite_rdy  in  1  consumer ready
- idle  out  1  no range pending, in flight, or buffered

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, dendrite_vld=0, dendrite_addr=0, dendrite_weight=0, clear_done=0, idle=0, skid empty, read-pending=0. RAM contents are not reset.
- syn_rdy is combinational: (state==IDLE) && ~clear_config.
- RAM word layout: [15:8] signed weight, [7:0] target neuron. Read latency is 1 cycle. Write port is owned by config/clear; read port is owned by the walker.
- Config (only when ~clear_config):
  - byte 1: shadow<=0
  - byte 2: shadow[15:8]<=config_value[7:0]
  - byte 3: shadow[7:0]<=config_value[7:0]
  - byte 4: write shadow to config_addr, takes effect next edge
  - Other config_byte values are ignored.
  - Config writes during RUN are legal and unordered relative to reads.
- FSM IDLE / RUN / CLEAR:
  - IDLE -> RUN on syn_vld&&syn_rdy: cur<=syn_start (13-bit counter), last<=syn_end.
  - If syn_end<syn_start, the range is empty: go to RUN, issue no reads, return to IDLE next cycle.
  - RUN: issue a read at addr cur and increment cur when cur<=last && ~skid_full && ~(dendrite_vld && ~dendrite_rdy).
  - RUN -> IDLE when cur>last, no read pending, and skid empty. The output register may still hold a valid event.
  - syn_end=4095: cur reaches 4096 (no wrap) and terminates correctly.
  - Any state -> CLEAR when clear_config=1.
- Output pipeline:
  - Read data arriving the cycle after issue loads the output register if it is free or being accepted; otherwise it loads the 1-entry skid.
  - The skid drains to the output register before new read data.
  - Events are emitted in ascending index order, with no drop and no duplicate.
  - Zero-weight synapses are emitted.
  - Latency: accept at edge E0; first dendrite_vld high after edge E2.
  - Throughput: 1 event per cycle with dendrite_rdy held high.
  - dendrite_addr and dendrite_weight are stable while dendrite_vld && ~dendrite_rdy.
- CLEAR:
  - Aborts any run: dendrite_vld<=0, skid flushed, pending read discarded.
  - Writes 0 to addresses 0..4095, one per cycle.
  - clear_done<=1 on the edge after the write to 4095; held while clear_config=1.
  - Deasserting clear_config returns to IDLE with clear_done<=0. Deassertion mid-sweep abandons the sweep; a later clear restarts at 0.
- idle (registered): state==IDLE && ~dendrite_vld && skid empty && ~syn_vld.
- Reset mid-operation forces all of the above reset values immediately; any partial range is lost.

Test Plan:
- Write synapses 10..12 = (w=+5,n=3), (w=-2,n=7), (w=0,n=9); send range 10..12, dendrite_rdy=1 -> 3 consecutive events (3,+5), (7,-2), (9,0); first after 2 edges; syn_rdy low until done; idle high afterward.
- Same range, dendrite_rdy low 4 cycles after the first event -> event (3,+5) held stable, no loss or duplication, order preserved, syn_rdy stays low.
- Range 4094..4095 -> exactly 2 events, FSM returns to IDLE, no wrap to index 0.
- Range start=20, end=19 -> no events; syn_rdy high again within 2 cycles.
- clear_config asserted mid-range -> dendrite_vld drops next edge; clear_done rises 4097 cycles later; reading any previously written synapse yields (n=0, w=0).
- Async reset asserted mid-range, between edges -> dendrite_vld=0 and clear_done=0 immediately; after release syn_rdy=1 and idle=1 within 1 cycle.
